// File: rtl/xalu_ise_pkg.sv
// Shared types and constants for the core-side custom-instruction (ISE) issue path.
package xalu_ise_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned IMM_W = 7;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] CUSTOM_0 = 2'd0;
  localparam logic [1:0] CUSTOM_1 = 2'd1;
  localparam logic [1:0] CUSTOM_2 = 2'd2;
  localparam logic [1:0] CUSTOM_3 = 2'd3;

  localparam logic [1:0] FUNCT_MADDLU = 2'b00;
  localparam logic [1:0] FUNCT_MADDHU = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [FN_W-1:0]  fn;
    logic [IMM_W-1:0] imm;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  rs3;
  } ise_req_t;

endpackage

// File: rtl/xalu_ise_tmo_cnt.sv
// Saturating 8-bit busy-cycle counter; hit flags the last cycle before an op is declared illegal.
module xalu_ise_tmo_cnt
  import xalu_ise_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/xalu_ise_issue.sv
// Issues one custom instruction to the XALU, waits for a unit to claim it, and returns the
// result (or an illegal-instruction flag after TIMEOUT unclaimed cycles) to the pipeline.
module xalu_ise_issue
  import xalu_ise_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             ise_clk,
  input  logic             ise_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FN_W-1:0]  req_fn,
  input  logic [IMM_W-1:0] req_imm,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [XLEN-1:0]  req_rs3,
  input  logic             req_kill,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic             rsp_illegal,
  output logic [FN_W-1:0]  ise_fn,
  output logic [IMM_W-1:0] ise_imm,
  output logic [XLEN-1:0]  ise_in1,
  output logic [XLEN-1:0]  ise_in2,
  output logic [XLEN-1:0]  ise_in3,
  output logic             ise_val,
  input  logic             ise_oval,
  input  logic [XLEN-1:0]  ise_out
);

  state_e          state_q, state_d;
  ise_req_t        hold_q, hold_d;
  ise_req_t        req_in;
  logic [XLEN-1:0] data_q, data_d;
  logic            ill_q, ill_d;
  logic            accept;
  logic            cnt_clr, cnt_en, cnt_hit;

  assign req_in = '{fn: req_fn, imm: req_imm, rs1: req_rs1, rs2: req_rs2, rs3: req_rs3};

  xalu_ise_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo_cnt (
    .clk (ise_clk),
    .rst (ise_rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  // State and holding registers.
  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state, operand capture, result capture and request acceptance.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    data_d    = data_q;
    ill_d     = ill_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    req_ready = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = ~req_kill;
        accept    = req_valid & ~req_kill;
        if (accept) begin
          hold_d  = req_in;
          cnt_clr = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Kill beats completion; a completing unit beats the timeout.
        if (req_kill) begin
          state_d = ST_IDLE;
        end else if (ise_oval) begin
          data_d  = ise_out;
          ill_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_hit) begin
          data_d  = '0;
          ill_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        req_ready = rsp_ready & ~req_kill;
        accept    = req_valid & rsp_ready & ~req_kill;
        if (accept) begin
          hold_d  = req_in;
          cnt_clr = 1'b1;
          state_d = ST_BUSY;
        end else if (rsp_ready || req_kill) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ise_val     = (state_q == ST_BUSY);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = data_q;
  assign rsp_illegal = ill_q;
  assign ise_fn      = hold_q.fn;
  assign ise_imm     = hold_q.imm;
  assign ise_in1     = hold_q.rs1;
  assign ise_in2     = hold_q.rs2;
  assign ise_in3     = hold_q.rs3;

endmodule

// File: doc/xalu_ise_issue.md
# xalu_ise_issue

Core-side issuer for the custom-instruction ISE port. It accepts one decoded custom instruction from the execute stage over a valid/ready handshake, registers the operands, and drives `ise_fn`/`ise_imm`/`ise_in1..3`/`ise_val` into the XALU. It waits for `ise_oval`, then returns `ise_out` to the pipeline over a second valid/ready handshake. Operations that no unit claims within `TIMEOUT` cycles complete with an illegal-instruction flag, so unimplemented functs (e.g. with the X25519 ISE disabled) trap instead of hanging.

## Interface
- `TIMEOUT`, default 4: maximum BUSY cycles without `ise_oval` before the operation is declared illegal; legal range 1..255.
- `ise_clk` in 1: clock.
- `ise_rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_fn` in 6: custom opcode selector; `[1:0]` is CUSTOM_0..3.
- `req_imm` in 7: funct field.
- `req_rs1`, `req_rs2`, `req_rs3` in 64 each: source operands.
- `req_kill` in 1: pipeline flush; aborts any in-flight operation.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: result consumed.
- `rsp_data` out 64: result; 0 when illegal.
- `rsp_illegal` out 1: no unit accepted the op.
- `ise_fn` out 6, `ise_imm` out 7, `ise_in1/2/3` out 64: registered copies of the request.
- `ise_val` out 1: operation valid.
- `ise_oval` in 1: a unit accepted and completed the op; may be combinational from `ise_val`.
- `ise_out` in 64: result, sampled only when `ise_oval`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - `req_ready=1` unless `req_kill`.
  - On handshake: latch fn, imm and rs1..3 into the holding registers, clear the counter, go BUSY.
- **BUSY**
  - `ise_val=1`; all `ise_*` outputs come from the holding registers and are stable for the whole state.
  - If `ise_oval`: latch `ise_out` into `rsp_data`, clear illegal, go RESP.
  - Else if counter == `TIMEOUT-1`: set `rsp_data=0` and `rsp_illegal=1`, go RESP.
  - Else increment the counter.
  - If `ise_oval` and timeout coincide, `ise_oval` wins.
- **RESP**
  - `rsp_valid=1`; `rsp_data` and `rsp_illegal` are held stable until the handshake.
  - On `rsp_ready`: go IDLE, or go straight to BUSY if a new request handshakes in the same cycle (`req_ready = rsp_ready & ~req_kill` in RESP).
- **Kill**
  - `req_kill` in BUSY or RESP: go IDLE next cycle; no response is produced; `ise_val` and `rsp_valid` drop next cycle.
  - Kill in IDLE: no request is accepted that cycle.
  - Kill in RESP with `rsp_ready=1` in the same cycle: the handshake completes and no new request is accepted.
- `ise_out` is ignored when `ise_oval=0`. `ise_oval` outside BUSY is ignored.
- The counter is 8 bits and saturates; it never wraps within one op.

## Timing
- Reset values: state IDLE, `req_ready=1`, `ise_val=0`, `rsp_valid=0`, `rsp_illegal=0`, `rsp_data=0`, `ise_fn/ise_imm/ise_in*=0`.
- Reset mid-operation discards the op with no response.
- Latency with a combinational XALU: request handshake in cycle 0, BUSY in cycle 1 (`ise_oval` seen), `rsp_valid` in cycle 2.
- Back-to-back throughput: one op per 2 cycles.
- Illegal op: `rsp_valid` with `rsp_illegal` at cycle `TIMEOUT+1`.
- All outputs are registered or decoded from state only; there is no combinational path from `ise_oval`/`ise_out` to any output.
  - Exception: `req_ready` in RESP depends on `rsp_ready`/`req_kill`.

## Structure
- Shared package `xalu_ise_pkg`:
  - CUSTOM_0..3 codes.
  - funct codes MADDLU=2'b00, MADDHU=2'b01.
  - state enum {IDLE, BUSY, RESP}.
  - 64-bit data width constant.
- One natural sub-module: `xalu_ise_tmo_cnt`, a saturating 8-bit counter with clear/enable and a `hit` output at `TIMEOUT-1`.
- The FSM and the holding registers stay in the top module.

## Test plan
- Legal op: `req_fn=6'h03`, `req_imm=7'h00`, rs1=`64'h2`, rs2=`64'h3`, rs3=`64'h5`. Stub XALU answers combinationally with `ise_oval=1`, `ise_out=64'hB`. Required: `ise_val` in cycle 1, `rsp_valid` in cycle 2 with `rsp_data=64'hB`, `rsp_illegal=0`.
- Unimplemented op: `req_fn=6'h00`, stub never asserts `ise_oval`, `TIMEOUT=4`. Required: `ise_val` high for exactly 4 cycles, then `rsp_valid=1`, `rsp_illegal=1`, `rsp_data=0`.
- Backpressure then back-to-back: hold `rsp_ready=0` for 5 cycles, with a second request pending. Required: `rsp_data` stable for all 5 cycles and `req_ready=0`. When `rsp_ready` rises, the second request is accepted that same cycle and its response arrives 2 cycles later.
- Kill during BUSY, with the stub delaying `ise_oval` by 3 cycles: assert `req_kill` on the 2nd BUSY cycle. Required: `ise_val=0` next cycle, no `rsp_valid`, and a late `ise_oval` is ignored.
- Coincident `ise_oval` and timeout: `TIMEOUT=1`, `ise_oval=1` in the first BUSY cycle with `ise_out=64'hDEAD`. Required: `rsp_illegal=0`, `rsp_data=64'hDEAD`.
- Synchronous reset asserted in RESP. Required: all outputs return to their reset values on the next edge, and no response is delivered.
